as_alu_arb: RTL

AS_ALU_ARB -- requirements
Module: as_alu_arb

---
 rtl/as_pack.sv | 26 ++
 rtl/as_alu.sv | 33 +++
 rtl/as_alu_arb.sv | 121 ++++++++++++
 3 files changed

// File: rtl/as_pack.sv
// Shared widths, ALU select codes and arbiter state encoding for the
// arbitrated ALU block.
package as_pack;

    localparam int reg_width    = 64;
    localparam int alusel_width = 4;

    localparam logic [alusel_width-1:0] ALU_AND = 4'b0000;
    localparam logic [alusel_width-1:0] ALU_OR  = 4'b0001;
    localparam logic [alusel_width-1:0] ALU_ADD = 4'b0010;
    localparam logic [alusel_width-1:0] ALU_XOR = 4'b0011;
    localparam logic [alusel_width-1:0] ALU_SUB = 4'b0110;
    localparam logic [alusel_width-1:0] ALU_SLT = 4'b0111;
    localparam logic [alusel_width-1:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } arb_state_t;

    function automatic logic [1:0] grant_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/as_alu.sv
// Purely combinational ALU shared by both requesters; codes it does not
// recognise yield a zero result rather than an error.
module as_alu
    import as_pack::*;
(
    input  logic [reg_width-1:0]    a,
    input  logic [reg_width-1:0]    b,
    input  logic [alusel_width-1:0] sel,
    output logic [reg_width-1:0]    result,
    output logic                    zero,
    output logic                    nega
);

    logic less;

    always_comb begin
        less   = $signed(a) < $signed(b);
        result = '0;
        case (sel)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_XOR: result = a ^ b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(reg_width-1){1'b0}}, less};
            ALU_NOR: result = ~(a | b);
            default: result = '0;
        endcase
        zero = (result == '0);
        nega = result[reg_width-1];
    end

endmodule

// File: rtl/as_alu_arb.sv
// Two-requester front end for a single shared ALU: grants one request,
// runs it for one cycle and holds the response until its owner takes it.
module as_alu_arb
    import as_pack::*;
#(
    parameter int RR_EN = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                req_valid_i,
    output logic [1:0]                req_ready_o,
    input  logic [2*reg_width-1:0]    req_a_i,
    input  logic [2*reg_width-1:0]    req_b_i,
    input  logic [2*alusel_width-1:0] req_sel_i,
    output logic [1:0]                rsp_valid_o,
    input  logic [1:0]                rsp_ready_i,
    output logic [reg_width-1:0]      rsp_result_o,
    output logic                      rsp_zero_o,
    output logic                      rsp_nega_o,
    output logic                      busy_o
);

    arb_state_t state;

    logic                    last_grant;
    logic                    owner;
    logic [reg_width-1:0]    op_a;
    logic [reg_width-1:0]    op_b;
    logic [alusel_width-1:0] op_sel;

    logic                    grant_idx;
    logic [reg_width-1:0]    grant_a;
    logic [reg_width-1:0]    grant_b;
    logic [alusel_width-1:0] grant_sel;
    logic                    req_hs;
    logic                    rsp_hs;

    logic [reg_width-1:0]    alu_result;
    logic                    alu_zero;
    logic                    alu_nega;

    // On a tie the round-robin pointer favours whoever was not served last.
    always_comb begin
        grant_idx = 1'b0;
        if (req_valid_i == 2'b11) begin
            grant_idx = (RR_EN != 0) ? ~last_grant : 1'b0;
        end else if (req_valid_i == 2'b10) begin
            grant_idx = 1'b1;
        end

        req_ready_o = 2'b00;
        if (state == IDLE && !rst && (req_valid_i != 2'b00)) begin
            req_ready_o = grant_onehot(grant_idx);
        end

        grant_a   = grant_idx ? req_a_i[2*reg_width-1:reg_width]       : req_a_i[reg_width-1:0];
        grant_b   = grant_idx ? req_b_i[2*reg_width-1:reg_width]       : req_b_i[reg_width-1:0];
        grant_sel = grant_idx ? req_sel_i[2*alusel_width-1:alusel_width] : req_sel_i[alusel_width-1:0];

        req_hs = (req_valid_i & req_ready_o) != 2'b00;
        rsp_hs = (state == RESP) && rsp_ready_i[owner];
    end

    as_alu u_alu (
        .a      (op_a),
        .b      (op_b),
        .sel    (op_sel),
        .result (alu_result),
        .zero   (alu_zero),
        .nega   (alu_nega)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            op_a         <= '0;
            op_b         <= '0;
            op_sel       <= '0;
            rsp_valid_o  <= 2'b00;
            rsp_result_o <= '0;
            rsp_zero_o   <= 1'b0;
            rsp_nega_o   <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_hs) begin
                        owner      <= grant_idx;
                        last_grant <= grant_idx;
                        op_a       <= grant_a;
                        op_b       <= grant_b;
                        op_sel     <= grant_sel;
                        busy_o     <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result_o <= alu_result;
                    rsp_zero_o   <= alu_zero;
                    rsp_nega_o   <= alu_nega;
                    rsp_valid_o  <= grant_onehot(owner);
                    state        <= RESP;
                end
                RESP: begin
                    // Only the owner's ready bit can retire the response.
                    if (rsp_hs) begin
                        rsp_valid_o <= 2'b00;
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
